// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front-end blocks: default image geometry,
// pixel width and the fill/run control state encoding of the window generator.
package cnn_pkg;

   localparam int CNN_WIDTH = 9;
   localparam int CNN_IMG_W = 28;
   localparam int CNN_IMG_H = 28;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } fillState_t;

endpackage

// File: rtl/line_buffer.sv
// Single-row line buffer: one combinational read port and one write port that
// share an address. A read and a write to the same slot in one cycle return
// the old contents, so the caller can move a row down before overwriting it.
module line_buffer #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 28,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_wrData,
   output logic [WIDTH-1:0] o_rdData
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   assign o_rdData = r_mem[i_addr];

   // Store the new value at the current column; contents are never reset
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wrData;
      end
   end

endmodule

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator. Pixels arrive in raster order; two line
// buffers hold the previous two rows and a 3x3 tap array shifts left on every
// accepted pixel. A window is presented the cycle after the pixel that
// completes a fully-inside (no padding) 3x3 neighbourhood, and is held while
// the downstream stage stalls.
module window_gen_3x3
   import cnn_pkg::*;
#(
   parameter int WIDTH = CNN_WIDTH,
   parameter int IMG_W = CNN_IMG_W,
   parameter int IMG_H = CNN_IMG_H
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic [WIDTH-1:0] w00,
   output logic [WIDTH-1:0] w01,
   output logic [WIDTH-1:0] w02,
   output logic [WIDTH-1:0] w10,
   output logic [WIDTH-1:0] w11,
   output logic [WIDTH-1:0] w12,
   output logic [WIDTH-1:0] w20,
   output logic [WIDTH-1:0] w21,
   output logic [WIDTH-1:0] w22,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   logic             w_accept;
   logic             w_colWrap;
   logic             w_frameWrap;
   logic             w_emit;
   logic             w_lastPix;
   fillState_t       r_state;
   fillState_t       w_stateNext;
   logic [CW-1:0]    r_col;
   logic [RW-1:0]    r_row;
   logic [WIDTH-1:0] w_lb0Rd;
   logic [WIDTH-1:0] w_lb1Rd;
   logic [WIDTH-1:0] r_tap [3][3];
   logic             r_outValid;
   logic             r_outLast;

   assign in_ready    = !r_outValid || out_ready;
   assign w_accept    = in_valid && in_ready;
   assign w_colWrap   = (r_col == COL_LAST);
   assign w_frameWrap = w_colWrap && (r_row == ROW_LAST);

   // lb0 holds the row above the current one, lb1 the row above that; lb1 is
   // refilled from lb0's old contents as lb0 takes the new pixel
   line_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (IMG_W),
      .AW    (CW)
   ) u_lb0 (
      .clk      (clk),
      .i_we     (w_accept),
      .i_addr   (r_col),
      .i_wrData (in_data),
      .o_rdData (w_lb0Rd)
   );

   line_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (IMG_W),
      .AW    (CW)
   ) u_lb1 (
      .clk      (clk),
      .i_we     (w_accept),
      .i_addr   (r_col),
      .i_wrData (w_lb0Rd),
      .o_rdData (w_lb1Rd)
   );

   // Raster position of the next pixel; wraps straight into the next frame
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (w_colWrap) begin
            r_col <= '0;
            r_row <= w_frameWrap ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   // Control state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FILL;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // FILL covers the first two rows where no full window exists; in RUN a
   // window is emitted once the column has reached 2
   always_comb begin
      w_stateNext = r_state;
      w_emit      = 1'b0;
      w_lastPix   = 1'b0;
      case (r_state)
         FILL: begin
            if (w_accept && w_colWrap && (r_row == ROW_ONE)) begin
               w_stateNext = RUN;
            end
         end
         RUN: begin
            w_emit    = w_accept && (r_col >= COL_TWO);
            w_lastPix = w_emit && w_frameWrap;
            if (w_accept && w_frameWrap) begin
               w_stateNext = FILL;
            end
         end
         default: begin
            w_stateNext = FILL;
         end
      endcase
   end

   // Tap array shifts left on accept; the new right column is the pixel and
   // the two line-buffer values read at its column
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               r_tap[r][c] <= '0;
            end
         end
      end else if (w_accept) begin
         for (int r = 0; r < 3; r++) begin
            r_tap[r][0] <= r_tap[r][1];
            r_tap[r][1] <= r_tap[r][2];
         end
         r_tap[0][2] <= w_lb1Rd;
         r_tap[1][2] <= w_lb0Rd;
         r_tap[2][2] <= in_data;
      end
   end

   // Output flags: reloaded on every accept, otherwise cleared once the
   // downstream stage takes the window
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outValid <= 1'b0;
         r_outLast  <= 1'b0;
      end else if (w_accept) begin
         r_outValid <= w_emit;
         r_outLast  <= w_lastPix;
      end else if (out_ready) begin
         r_outValid <= 1'b0;
         r_outLast  <= 1'b0;
      end
   end

   assign out_valid = r_outValid;
   assign out_last  = r_outLast;
   assign w00 = r_tap[0][0];
   assign w01 = r_tap[0][1];
   assign w02 = r_tap[0][2];
   assign w10 = r_tap[1][0];
   assign w11 = r_tap[1][1];
   assign w12 = r_tap[1][2];
   assign w20 = r_tap[2][0];
   assign w21 = r_tap[2][1];
   assign w22 = r_tap[2][2];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Testbench for window_gen_3x3: a 4x4 instance for the directed scenarios and
// a 28x28 instance for random data, both checked against a 3x3 slicer model
// that cuts windows straight out of the pixel stream.
module tb_window_gen_3x3;

   localparam int WD = 9;

   typedef struct packed {
      logic [9*WD-1:0] win;
      logic            last;
   } win_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          inValid;
   logic [WD-1:0] inData;
   logic          outReady;
   logic          sel;

   logic          v4, v28;
   logic          rdy4, rdy28;
   logic          ov4, ov28, ol4, ol28;
   logic [WD-1:0] t4 [9];
   logic [WD-1:0] t28 [9];

   logic [9*WD-1:0] obsWin;
   logic            obsValid;
   logic            obsLast;
   logic            obsInReady;

   int errors = 0;
   int checks = 0;

   logic [WD-1:0]   stream [$];
   win_t            expQ [$];
   logic [9*WD-1:0] gotQ [$];
   logic [9*WD-1:0] scen1 [$];

   always #5 clk = ~clk;

   assign v4  = inValid && !sel;
   assign v28 = inValid && sel;

   window_gen_3x3 #(.WIDTH(WD), .IMG_W(4), .IMG_H(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_data(inData), .in_ready(rdy4),
      .w00(t4[0]), .w01(t4[1]), .w02(t4[2]),
      .w10(t4[3]), .w11(t4[4]), .w12(t4[5]),
      .w20(t4[6]), .w21(t4[7]), .w22(t4[8]),
      .out_valid(ov4), .out_last(ol4), .out_ready(outReady)
   );

   window_gen_3x3 #(.WIDTH(WD), .IMG_W(28), .IMG_H(28)) dut28 (
      .clk(clk), .rst(rst), .in_valid(v28), .in_data(inData), .in_ready(rdy28),
      .w00(t28[0]), .w01(t28[1]), .w02(t28[2]),
      .w10(t28[3]), .w11(t28[4]), .w12(t28[5]),
      .w20(t28[6]), .w21(t28[7]), .w22(t28[8]),
      .out_valid(ov28), .out_last(ol28), .out_ready(outReady)
   );

   // Present whichever instance is under test on one set of observation nets
   always_comb begin
      if (sel) begin
         obsWin     = {t28[0], t28[1], t28[2], t28[3], t28[4], t28[5], t28[6], t28[7], t28[8]};
         obsValid   = ov28;
         obsLast    = ol28;
         obsInReady = rdy28;
      end else begin
         obsWin     = {t4[0], t4[1], t4[2], t4[3], t4[4], t4[5], t4[6], t4[7], t4[8]};
         obsValid   = ov4;
         obsLast    = ol4;
         obsInReady = rdy4;
      end
   end

   task automatic checkOutput(input string tag, input logic [9*WD-1:0] obs, input logic [9*WD-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic failNow(input string tag);
      checks++;
      errors++;
      $error("[TB] FAIL %s", tag);
   endtask

   task automatic applyReset();
      rst      = 1'b1;
      inValid  = 1'b0;
      inData   = '0;
      outReady = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
   endtask

   // Every fully-inside 3x3 neighbourhood of a W x H frame stored in the
   // stream starting at base, in raster order of its bottom-right pixel
   task automatic modelFrame(input int W, input int H, input int base);
      win_t e;
      for (int r = 2; r < H; r++) begin
         for (int c = 2; c < W; c++) begin
            e.win = '0;
            for (int i = 0; i < 3; i++) begin
               for (int j = 0; j < 3; j++) begin
                  e.win = {e.win[8*WD-1:0], stream[base + (r - 2 + i) * W + (c - 2 + j)]};
               end
            end
            e.last = (r == H - 1) && (c == W - 1);
            expQ.push_back(e);
         end
      end
   endtask

   // Feed the stream, stalling out_ready for stallCycles at the first window,
   // and score every transfer against the model queue
   task automatic applyStimulus(input int stallCycles, input bit toggle, input int maxCycles, input string tag);
      int   idx = 0;
      int   cyc = 0;
      int   stallLeft = stallCycles;
      bit   phase = 1'b0;
      win_t e;
      while ((idx < stream.size() || expQ.size() > 0) && cyc < maxCycles) begin
         inValid  = (idx < stream.size()) && (!toggle || !phase);
         inData   = (idx < stream.size()) ? stream[idx] : '0;
         outReady = 1'b1;
         if (stallLeft > 0 && obsValid) outReady = 1'b0;
         #1;
         if (!outReady) begin
            checkOutput({tag, " stall in_ready"}, 81'(obsInReady), 81'(0));
            if (expQ.size() > 0) checkOutput({tag, " held window"}, obsWin, expQ[0].win);
            stallLeft--;
         end
         if (obsValid && outReady) begin
            if (expQ.size() == 0) begin
               failNow({tag, " unexpected window"});
            end else begin
               e = expQ.pop_front();
               checkOutput({tag, " window"}, obsWin, e.win);
               checkOutput({tag, " last"}, 81'(obsLast), 81'(e.last));
               gotQ.push_back(obsWin);
            end
         end
         if (inValid && obsInReady) idx++;
         @(posedge clk);
         #1;
         phase = ~phase;
         cyc++;
      end
      inValid = 1'b0;
      if (cyc >= maxCycles) failNow({tag, " timeout"});
      #1;
      checkOutput({tag, " no trailing window"}, 81'(obsValid), 81'(0));
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " out_valid"}, 81'(obsValid), 81'(0));
      checkOutput({tag, " out_last"}, 81'(obsLast), 81'(0));
      checkOutput({tag, " in_ready"}, 81'(obsInReady), 81'(1));
      checkOutput({tag, " taps"}, obsWin, '0);
   endtask

   initial begin
      logic [9*WD-1:0] firstWin;
      logic [9*WD-1:0] secondWin;
      logic [9*WD-1:0] frame2Win;
      firstWin  = {9'd0, 9'd1, 9'd2, 9'd4, 9'd5, 9'd6, 9'd8, 9'd9, 9'd10};
      secondWin = {9'd1, 9'd2, 9'd3, 9'd5, 9'd6, 9'd7, 9'd9, 9'd10, 9'd11};
      frame2Win = {9'd100, 9'd101, 9'd102, 9'd104, 9'd105, 9'd106, 9'd108, 9'd109, 9'd110};

      sel = 1'b0;
      applyReset();
      repeat (2) @(posedge clk);
      #1;
      checkResetState("reset4");
      sel = 1'b1;
      #1;
      checkResetState("reset28");
      sel = 1'b0;
      #1;

      $display("[TB] scenario 1: 4x4 frame, no backpressure");
      stream.delete(); expQ.delete(); gotQ.delete();
      for (int i = 0; i < 16; i++) stream.push_back(WD'(i));
      modelFrame(4, 4, 0);
      applyStimulus(0, 1'b0, 200, "s1");
      checkOutput("s1 count", 81'(gotQ.size()), 81'(4));
      checkOutput("s1 first window", gotQ[0], firstWin);
      checkOutput("s1 second window", gotQ[1], secondWin);
      scen1 = gotQ;

      $display("[TB] scenario 2: 5-cycle stall at first window");
      expQ.delete(); gotQ.delete();
      modelFrame(4, 4, 0);
      applyStimulus(5, 1'b0, 200, "s2");
      checkOutput("s2 count", 81'(gotQ.size()), 81'(4));

      $display("[TB] scenario 3: back-to-back frames");
      stream.delete(); expQ.delete(); gotQ.delete();
      for (int i = 0; i < 16; i++) stream.push_back(WD'(i));
      for (int i = 0; i < 16; i++) stream.push_back(WD'(100 + i));
      modelFrame(4, 4, 0);
      modelFrame(4, 4, 16);
      applyStimulus(0, 1'b0, 300, "s3");
      checkOutput("s3 count", 81'(gotQ.size()), 81'(8));
      checkOutput("s3 frame2 first window", gotQ[4], frame2Win);

      $display("[TB] scenario 4: reset mid-frame");
      stream.delete(); expQ.delete(); gotQ.delete();
      for (int i = 0; i < 10; i++) stream.push_back(WD'(i));
      applyStimulus(0, 1'b0, 100, "s4a");
      applyReset();
      stream.delete();
      for (int i = 0; i < 16; i++) stream.push_back(WD'(i));
      modelFrame(4, 4, 0);
      applyStimulus(0, 1'b0, 200, "s4b");
      checkOutput("s4 count", 81'(gotQ.size()), 81'(4));
      for (int i = 0; i < 4; i++) checkOutput($sformatf("s4 match s1 #%0d", i), gotQ[i], scen1[i]);

      $display("[TB] scenario 5: 28x28 random data, in_valid toggling");
      sel = 1'b1;
      #1;
      stream.delete(); expQ.delete(); gotQ.delete();
      for (int i = 0; i < 28 * 28; i++) stream.push_back(WD'($urandom_range(0, 511)));
      modelFrame(28, 28, 0);
      applyStimulus(0, 1'b1, 5000, "s5");
      checkOutput("s5 count", 81'(gotQ.size()), 81'(676));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Sliding-window generator that sits directly upstream of the 3×3 convolution unit. It accepts a raster-order pixel stream, one pixel per handshake, and buffers the previous two image rows in line buffers. For every valid (no-padding) output position it presents a registered 3×3 window whose nine outputs wire one-to-one onto the conv unit's `a00..a22` inputs. Output count per frame is (IMG_W−2)×(IMG_H−2).

## Interface
- `WIDTH`, 9: pixel bit width; matches the conv unit operand width.
- `IMG_W`, 28: pixels per row; legal range ≥3.
- `IMG_H`, 28: rows per frame; legal range ≥3.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `in_data` is valid.
- `in_data`  in  WIDTH: pixel, raster order (row-major, col 0 first).
- `in_ready`  out  1: the block can accept a pixel this cycle.
- `w00..w22`  out  WIDTH each: window; `wRC` is row R (0 = oldest), column C (0 = leftmost).
- `out_valid`  out  1: window is valid.
- `out_last`  out  1: the window is the final one of the frame; qualified by `out_valid`.
- `out_ready`  in  1: the downstream conv stage takes the window.

## Operation
- Accept pixel ⇔ `in_valid && in_ready`. Transfer out ⇔ `out_valid && out_ready`.
- Counters:
  - `col` runs 0..IMG_W−1. `row` runs 0..IMG_H−1.
  - Both advance only on accept.
  - `col` wraps to 0 and increments `row`. After (IMG_H−1, IMG_W−1), both wrap to (0,0) and the next frame begins with no gap.
- Line buffers `lb0` (row r−1) and `lb1` (row r−2), each IMG_W deep, are indexed by `col`.
  - On accept of pixel p at col c: read `lb0[c]` and `lb1[c]`.
  - Then write `lb1[c] ← old lb0[c]` and `lb0[c] ← p` (read-before-write at the same address).
- Tap registers form three 3-deep shift rows, shifted left on accept.
  - New rightmost column: `w02 ← lb1[c]`, `w12 ← lb0[c]`, `w22 ← p`.
  - `w00/w01` ← old `w01/w02`. Rows 1 and 2 shift the same way.
- Emission rule: when the accepted pixel has `row≥2 && col≥2`, `out_valid` is set next cycle. `out_last` is set if the pixel was (IMG_H−1, IMG_W−1). Otherwise `out_valid` clears on a transfer.
- Stale taps at col 0/1 and stale line-buffer content from the previous frame at rows 0/1 are never emitted; the emission rule masks them.
- Control FSM:
  - `FILL`: row<2. Accept freely; no output.
  - `RUN`: row≥2. Output is gated by `col`.
  - `RUN→FILL` on the frame-wrap accept.
- Arithmetic: counters are $clog2(IMG_W) and $clog2(IMG_H) bits. No data arithmetic; pixels pass bit-exact.

## Timing
- Latency: accept at cycle t → window on outputs at t+1.
- Backpressure:
  - `in_ready = !out_valid || out_ready` (single output stage).
  - While `out_valid && !out_ready`, `w00..w22`, `out_valid` and `out_last` are held stable.
- Simultaneous transfer out and accept in the same cycle is legal; throughput is 1 pixel/cycle with `out_ready` high.
- Reset values:
  - `out_valid=0`, `out_last=0`, `w**=0`.
  - `in_ready=1` from the first cycle after reset.
  - `row=col=0`, FSM=`FILL`. Line buffers are not reset.
- Reset mid-frame: the partial frame is discarded, the next accepted pixel is (0,0), and no window is emitted until row 2 col 2.
- `in_valid` low: counters and taps are frozen; `out_valid` still clears on transfer.

## Structure
- Shared package `cnn_pkg`: default `WIDTH`, `IMG_W`, `IMG_H`, and the FSM state encoding (`FILL`, `RUN`).
- Sub-module `line_buffer`:
  - IMG_W×WIDTH RAM, one read and one write port, same address, read-before-write.
  - Instantiated twice, or once at 2·WIDTH wide.
- Top level holds the counters, FSM, tap shift registers and output stage. RTL is 150–250 lines.

## Test plan
- IMG_W=IMG_H=4, pixels 0..15, `out_ready=1`: exactly 4 windows.
  - First window: w00..w22 = 0,1,2 / 4,5,6 / 8,9,10.
  - The remaining windows are centred on pixels 6, 9 and 10; `out_last` is set on the window with w22=15 only.
- Same stream with `out_ready` low for 5 cycles at the first window: `in_ready=0`, window held at 0..10, no pixel lost. All 4 windows appear in order afterwards.
- Two back-to-back frames (0..15 then 100..115): the second frame's first window is 100,101,102 / 104,105,106 / 108,109,110, with no window before it.
- Reset asserted after pixel 9, then stream 0..15 again: outputs match the first scenario exactly.
- `in_valid` toggling 1-0-1-0 on IMG_W=IMG_H=28 random data: 676 windows, each matching a reference 3×3 slicer.
- After reset, with no input: `out_valid=0`, `out_last=0`, `in_ready=1`, all taps 0.
